// File: rtl/batt_a2d_pkg.sv
// Shared types and widths for the battery A2D acquisition slice.
package batt_a2d_pkg;

  localparam int unsigned ADC_CMD_W = 16;
  localparam int unsigned ADC_RES_W = 12;
  localparam int unsigned BATT_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CH_FRM,
    ST_GAP,
    ST_RD_FRM,
    ST_DONE
  } top_state_e;

  typedef enum logic [1:0] {
    SPI_IDLE,
    SPI_FRONT,
    SPI_SHIFT,
    SPI_BACK
  } spi_state_e;

  // ADC128S control word: channel address sits in bits [13:11].
  function automatic logic [ADC_CMD_W-1:0] adc_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/batt_a2d_mon_if.sv
// Command-side and SPI-side signals of batt_a2d_mon grouped as one bundle.
interface batt_a2d_mon_if;
  import batt_a2d_pkg::*;

  logic              strt_cnv;
  logic              MISO;
  logic              SS_n;
  logic              SCLK;
  logic              MOSI;
  logic [BATT_W-1:0] batt;
  logic              cnv_cmplt;
  logic              busy;

  modport master (
    input  strt_cnv, MISO,
    output SS_n, SCLK, MOSI, batt, cnv_cmplt, busy
  );

  modport slave (
    output strt_cnv, MISO,
    input  SS_n, SCLK, MOSI, batt, cnv_cmplt, busy
  );

endinterface

// File: rtl/spi_mstr16.sv
// 16-bit SPI master, SCLK idles high, MOSI changes on SCLK fall, MISO sampled on rise.
module spi_mstr16
  import batt_a2d_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wrt,
  input  logic [ADC_CMD_W-1:0] cmd,
  input  logic                 MISO,
  output logic                 SS_n,
  output logic                 SCLK,
  output logic                 MOSI,
  output logic [ADC_CMD_W-1:0] rd,
  output logic                 done
);

  localparam int unsigned CW = $clog2(SCLK_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_DIV / 2 - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(SCLK_DIV - 1);

  spi_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [4:0]           bit_q, bit_d;
  logic [ADC_CMD_W-1:0] shift_q, shift_d;
  logic                 sclk_q, sclk_d;
  logic                 ss_n_q, ss_n_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SPI_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b1;
      ss_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      ss_n_q  <= ss_n_d;
      done_q  <= done_d;
    end
  end

  // Counter restarts at each SCLK fall; rise lands half a period later.
  // Bit 0 is refilled from MISO on the rise; the whole word shifts on falls 2..16.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    ss_n_d  = ss_n_q;
    done_d  = 1'b0;
    unique case (state_q)
      SPI_IDLE: begin
        if (wrt) begin
          state_d = SPI_FRONT;
          ss_n_d  = 1'b0;
          sclk_d  = 1'b1;
          shift_d = cmd;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      SPI_FRONT: begin
        if (cnt_q == HALF_LAST) begin
          sclk_d  = 1'b0;
          cnt_d   = '0;
          state_d = SPI_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SPI_SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          sclk_d  = 1'b1;
          shift_d = {shift_q[ADC_CMD_W-1:1], MISO};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 5'd15) begin
            state_d = SPI_BACK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q == DIV_LAST) begin
          sclk_d  = 1'b0;
          shift_d = {shift_q[ADC_CMD_W-2:0], 1'b0};
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SPI_BACK: begin
        if (cnt_q == HALF_LAST) begin
          ss_n_d  = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = SPI_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SPI_IDLE;
    endcase
  end

  assign SS_n = ss_n_q;
  assign SCLK = sclk_q;
  assign MOSI = shift_q[ADC_CMD_W-1];
  assign rd   = shift_q;
  assign done = done_q;

endmodule

// File: rtl/batt_a2d_mon.sv
// Battery-level acquisition: two-frame ADC128S conversion per strt_cnv, batt = result[11:4].
module batt_a2d_mon
  import batt_a2d_pkg::*;
#(
  parameter logic [2:0]  CHANNEL  = 3'd0,
  parameter int unsigned SCLK_DIV = 32,
  parameter int unsigned GAP_CYC  = 32
) (
  input  logic           clk,
  input  logic           rst,
  batt_a2d_mon_if.master bus
);

  localparam int unsigned GW = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  top_state_e           state_q, state_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 wrt_q, wrt_d;
  logic [BATT_W-1:0]    batt_q, batt_d;
  logic [ADC_CMD_W-1:0] rd_w;
  logic                 done_w;
  logic                 unused_rd_bits;

  spi_mstr16 #(.SCLK_DIV(SCLK_DIV)) u_spi (
    .clk  (clk),
    .rst  (rst),
    .wrt  (wrt_q),
    .cmd  (adc_cmd(CHANNEL)),
    .MISO (bus.MISO),
    .SS_n (bus.SS_n),
    .SCLK (bus.SCLK),
    .MOSI (bus.MOSI),
    .rd   (rd_w),
    .done (done_w)
  );

  assign unused_rd_bits = ^{rd_w[ADC_CMD_W-1:ADC_RES_W], rd_w[ADC_RES_W-BATT_W-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      wrt_q   <= 1'b0;
      batt_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      wrt_q   <= wrt_d;
      batt_q  <= batt_d;
    end
  end

  // batt is loaded on entry to DONE so it is already valid while cnv_cmplt is high.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    wrt_d   = 1'b0;
    batt_d  = batt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.strt_cnv) begin
          state_d = ST_CH_FRM;
          wrt_d   = 1'b1;
        end
      end
      ST_CH_FRM: begin
        if (done_w) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_RD_FRM;
          wrt_d   = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_RD_FRM: begin
        if (done_w) begin
          batt_d  = rd_w[ADC_RES_W-1:ADC_RES_W-BATT_W];
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.batt      = batt_q;
  assign bus.cnv_cmplt = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_CH_FRM) || (state_q == ST_GAP) || (state_q == ST_RD_FRM);

endmodule

// File: tb/tb_batt_a2d_mon.sv
// Self-checking bench for batt_a2d_mon with an ADC128S-style MISO model and batt scoreboard.
module tb_batt_a2d_mon;
  import batt_a2d_pkg::*;

  localparam int DIV     = 32;
  localparam int H       = DIV / 2;
  localparam int GAP     = 32;
  localparam int FRAME_W = 16 * DIV + H;
  localparam int LAT     = 2 * (FRAME_W + 1) + GAP + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  batt_a2d_mon_if if0 ();
  batt_a2d_mon_if if1 ();

  batt_a2d_mon #(.CHANNEL(3'd0), .SCLK_DIV(DIV), .GAP_CYC(GAP)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.master)
  );

  batt_a2d_mon #(.CHANNEL(3'd5), .SCLK_DIV(DIV), .GAP_CYC(GAP)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.master)
  );

  logic       sel;
  logic       miso_r;
  logic [11:0] adc_val;
  logic       m_ssn, m_sclk, m_mosi, m_cmplt, m_busy;
  logic [7:0] m_batt;

  assign if0.MISO = miso_r;
  assign if1.MISO = miso_r;
  assign m_ssn   = sel ? if1.SS_n      : if0.SS_n;
  assign m_sclk  = sel ? if1.SCLK      : if0.SCLK;
  assign m_mosi  = sel ? if1.MOSI      : if0.MOSI;
  assign m_cmplt = sel ? if1.cnv_cmplt : if0.cnv_cmplt;
  assign m_busy  = sel ? if1.busy      : if0.busy;
  assign m_batt  = sel ? if1.batt      : if0.batt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int cnv_cnt = 0;

  logic [7:0]  sb[$];
  int          w_q[$];
  int          r_q[$];
  logic [15:0] mosi_q[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  always @(posedge clk) cyc++;

  // ADC model and frame monitor
  logic        ssn_prev = 1'b1, sclk_prev = 1'b1;
  int          idx, low_cnt, rises;
  bit          first_fall;
  logic [15:0] adc_word, mosi_w;
  always @(negedge clk) begin
    adc_word = {4'b0000, adc_val};
    if (ssn_prev && !m_ssn) begin
      idx = 15; first_fall = 1'b1; miso_r = adc_word[15];
      low_cnt = 0; rises = 0; mosi_w = '0;
    end else if (!m_ssn && sclk_prev && !m_sclk) begin
      if (first_fall) first_fall = 1'b0;
      else if (idx > 0) begin idx--; miso_r = adc_word[idx]; end
    end
    if (!m_ssn && !sclk_prev && m_sclk) begin
      rises++;
      mosi_w = {mosi_w[14:0], m_mosi};
    end
    if (!m_ssn) low_cnt++;
    if (!ssn_prev && m_ssn) begin
      w_q.push_back(low_cnt);
      r_q.push_back(rises);
      mosi_q.push_back(mosi_w);
    end
    ssn_prev  = m_ssn;
    sclk_prev = m_sclk;
  end

  // Scoreboard: batt compared one cycle after cnv_cmplt, latency at the pulse
  bit         batt_pend = 1'b0;
  logic [7:0] batt_exp;
  int         lat;
  always @(negedge clk) begin
    if (batt_pend) begin
      chk("batt", m_batt, batt_exp);
      batt_pend = 1'b0;
    end
    if (m_cmplt === 1'b1) begin
      cnv_cnt++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_cnv: got cnv_cmplt expected none (t=%0t)", $time);
      end else begin
        batt_exp  = sb.pop_front();
        batt_pend = 1'b1;
        lat = cyc - start_cyc;
        checks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
          errors++;
          $display("FAIL latency: got %0d expected %0d+-1", lat, LAT);
        end
      end
    end
  end

  task automatic set_strt(input logic b);
    if (sel) if1.strt_cnv = b;
    else     if0.strt_cnv = b;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    set_strt(1'b1);
    start_cyc = cyc + 1;
    @(negedge clk);
    set_strt(1'b0);
  endtask

  task automatic run_conv(input logic [11:0] v, input logic [7:0] eb,
                          input bit repulse, input bit poke_done);
    int n;
    int c0;
    logic [15:0] ecmd;
    ecmd = sel ? 16'h2800 : 16'h0000;
    adc_val = v;
    w_q.delete(); r_q.delete(); mosi_q.delete();
    c0 = cnv_cnt;
    sb.push_back(eb);
    start_pulse();
    n = 0;
    while (m_cmplt !== 1'b1 && n < LAT + 200) begin
      @(negedge clk);
      n++;
      set_strt(repulse && (n == 100 || n == 545));
      if (n == 300) chk("busy_mid", m_busy, 1);
      if (repulse && n == 545) chk("gap_ssn_high", m_ssn, 1);
    end
    if (n >= LAT + 200) chk("cnv_timeout", 0, 1);
    set_strt(poke_done);
    @(negedge clk);
    set_strt(1'b0);
    chk("cmplt_one_cycle", m_cmplt, 0);
    chk("busy_after_done", m_busy, 0);
    repeat (2) @(negedge clk);
    chk("busy_idle", m_busy, 0);
    chk("ssn_idle", m_ssn, 1);
    chk("cnv_count", cnv_cnt, c0 + 1);
    chk("frames", w_q.size(), 2);
    for (int i = 0; i < w_q.size(); i++) begin
      chk("ssn_low_width", w_q[i], FRAME_W);
      chk("sclk_rises", r_q[i], 16);
      chk("mosi_word", mosi_q[i], ecmd);
    end
  endtask

  typedef struct {
    logic [11:0] adc;
    logic [7:0]  exp_b;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int c0;
    vecs[0] = '{adc: 12'hA5C, exp_b: 8'hA5};
    vecs[1] = '{adc: 12'hFFF, exp_b: 8'hFF};
    vecs[2] = '{adc: 12'h00F, exp_b: 8'h00};
    vecs[3] = '{adc: 12'h800, exp_b: 8'h80};
    vecs[4] = '{adc: 12'h7FF, exp_b: 8'h7F};
    vecs[5] = '{adc: 12'h1E3, exp_b: 8'h1E};

    rst = 1'b1; sel = 1'b0; adc_val = '0; miso_r = 1'b0;
    if0.strt_cnv = 1'b0; if1.strt_cnv = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ssn", if0.SS_n, 1);
    chk("rst_sclk", if0.SCLK, 1);
    chk("rst_mosi", if0.MOSI, 0);
    chk("rst_batt", if0.batt, 8'h00);
    chk("rst_busy", if0.busy, 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("idle_ssn", if0.SS_n, 1);
    chk("idle_sclk", if0.SCLK, 1);
    chk("idle_batt", if0.batt, 8'h00);
    chk("idle_ssn_ch5", if1.SS_n, 1);
    chk("idle_no_cnv", cnv_cnt, 0);

    for (int i = 0; i < 6; i++) run_conv(vecs[i].adc, vecs[i].exp_b, 1'b0, 1'b0);

    sel = 1'b1;
    run_conv(12'h3C7, 8'h3C, 1'b0, 1'b0);
    chk("ch0_batt_held", if0.batt, 8'h1E);
    sel = 1'b0;

    // Re-pulses in CH_FRM/GAP and a pulse in the DONE cycle are all dropped
    run_conv(12'h5A0, 8'h5A, 1'b1, 1'b1);
    c0 = cnv_cnt;
    w_q.delete();
    repeat (LAT + 100) @(negedge clk);
    chk("no_extra_cnv", cnv_cnt, c0);
    chk("no_extra_frames", w_q.size(), 0);
    chk("batt_holds", if0.batt, 8'h5A);
    run_conv(12'h0F0, 8'h0F, 1'b0, 1'b0);

    // Reset in the middle of the read frame
    adc_val = 12'h9D3;
    sb.push_back(8'h9D);
    c0 = cnv_cnt;
    start_pulse();
    repeat (900) @(negedge clk);
    chk("rdfrm_ssn_low", if0.SS_n, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ssn", if0.SS_n, 1);
    chk("midrst_sclk", if0.SCLK, 1);
    chk("midrst_batt", if0.batt, 8'h00);
    chk("midrst_busy", if0.busy, 0);
    chk("midrst_cmplt", if0.cnv_cmplt, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 100) @(negedge clk);
    chk("midrst_no_cnv", cnv_cnt, c0);
    chk("midrst_batt_stays", if0.batt, 8'h00);
    run_conv(12'h6B9, 8'h6B, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
